pwm_cfg_sched: RTL
==================

Name: pwm_cfg_sched

Overview:
- Configuration scheduler for the two PWM channels.
- Accepts new (high, top, div) settings from a single requester over a valid/ready handshake and holds them in a per-channel shadow.
- Commits each shadow to the live PWM setting only at that channel's period boundary, so PWM outputs never glitch mid-period.
- Sits between the register-write path and the PWM counters; a watchdog forces commit if a boundary never arrives.

Parameters:
- NCHAN, 2, number of PWM channels scheduled (channel index width is $clog2(NCHAN), min 1).
- TIMEOUT, 65536, cycles a pending update may wait before forced commit.
- TW, 17, width of each per-channel timeout counter (must hold TIMEOUT).

Ports:
- clock  input  1  system clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  update request present
- req_ready  output  1  scheduler can accept request for req_chan
- req_chan  input  1  target channel index
- req_high  input  16  new high count
- req_top  input  16  new period top count
- req_div  input  8  new clock divider (0 = channel off)
- req_err  output  1  one-cycle pulse: request rejected
- period_end  input  NCHAN  per-channel one-cycle pulse when PWM counter wraps top->0
- act_high  output  16*NCHAN  live high count, channel c at [16c+15:16c]
- act_top  output  16*NCHAN  live top count, packed likewise
- act_div  output  8*NCHAN  live divider, packed likewise
- pending  output  NCHAN  shadow holds an uncommitted update
- commit  output  NCHAN  one-cycle pulse: channel's live setting updated this cycle
- late_commit  output  NCHAN  one-cycle pulse: commit forced by timeout

Behaviour:
- Reset (synchronous, evaluated at posedge clock):
  - act_high/act_top/act_div = 0, so all channels are off.
  - Shadows = 0; all channels IDLE; timeout counters = 0.
  - req_err, commit, late_commit = 0.
- Per-channel FSM has two states, IDLE and PENDING.
- req_ready is combinational: 1 iff channel req_chan is IDLE and reset is 0.
- Handshake:
  - A transfer occurs on a posedge with req_valid & req_ready.
  - Validation: the request is rejected if req_div != 0 and (req_top == 0 or req_high > req_top + 1, compared at 17 bits).
  - On reject: req_err = 1 the next cycle; shadow and state unchanged; transfer still completes (no retry stall).
  - On accept: shadow[c] is loaded, state goes to PENDING, and the timeout counter is cleared.
  - req_valid with req_ready = 0: no effect; the requester must hold its request.
- Commit from PENDING, evaluated each cycle for channel c:
  - Stopped channel: if act_div[c] == 0, commit on the first PENDING cycle. Latency is 1 cycle after accept (accept edge N, live updated at edge N+1).
  - Period boundary: else if period_end[c] == 1, commit at that edge.
  - Watchdog: else if timeout counter == TIMEOUT-1, commit and pulse late_commit[c]. Otherwise the counter increments.
  - On commit: act_*[c] <= shadow[c]; commit[c] = 1 for exactly the following cycle; state goes to IDLE.
- Simultaneous events:
  - period_end[c] on the same edge as an accept into IDLE channel c is ignored; the commit waits for the next boundary.
  - Accept for channel a and commit for channel b≠a in the same cycle are independent.
  - period_end while IDLE has no effect.
- The new config may set div = 0. That is legal: it turns the channel off at the boundary, with no validation of high/top.
- Reset mid-PENDING discards the shadow and returns the live setting to 0; no commit pulse.
- Timeout counter saturates and never wraps, because commit occurs at TIMEOUT-1.
- pending[c] = (state[c] == PENDING), registered.

Decomposition:
- Shared package pwm_pkg holds:
  - typedef pwm_cfg_t (struct: high 16, top 16, div 8)
  - typedef enum cfg_state_t {IDLE, PENDING}
  - constants PWM_NCHAN = 2, PWM_CFG_W = 40
- Sub-module pwm_cfg_slot: one channel's FSM, shadow, live register and timeout counter, instantiated NCHAN times.
- The top level holds the validation, ready mux and err pulse.

Test Plan:
- Reset, then accept ch0 (high 100, top 200, div 4) while act_div = 0 → act ch0 = {100,200,4} one cycle after accept; commit[0] pulse; pending[0] back to 0.
- Ch0 live, div 4; new request {50,200,4} → pending[0] = 1, act unchanged until period_end[0] pulses 37 cycles later; act updates on that edge, commit[0] = 1 the next cycle.
- Ch1 PENDING, second request to ch1 → req_ready = 0 for the whole wait; request to ch0 in the same window is accepted; no overwrite of ch1's shadow.
- Request {300,200,4} → req_err pulse; {0,0,0} → accepted (off); {201,200,1} → accepted (boundary legal, 100% duty).
- TIMEOUT = 16, period_end never asserted → commit and late_commit pulse together exactly 16 cycles after accept.
- Reset asserted while ch0 PENDING with period_end coincident → act = 0, pending = 0, no commit pulse.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM configuration scheduler.
package pwm_pkg;

  localparam int unsigned PWM_NCHAN = 2;
  localparam int unsigned PWM_CFG_W = 40;

  typedef struct packed {
    logic [15:0] high;
    logic [15:0] top;
    logic [7:0]  div;
  } pwm_cfg_t;

  typedef enum logic {
    IDLE    = 1'b0,
    PENDING = 1'b1
  } cfg_state_t;

  // A stopped channel (div == 0) ignores high/top; otherwise high may reach top+1 (100% duty).
  function automatic logic cfg_ok(pwm_cfg_t c);
    return (c.div == '0) ||
           ((c.top != '0) && ({1'b0, c.high} <= ({1'b0, c.top} + 17'd1)));
  endfunction

endpackage

// File: rtl/pwm_cfg_slot.sv
// One channel: shadow register, live setting, commit FSM and watchdog counter.
module pwm_cfg_slot
  import pwm_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65536,
  parameter int unsigned TW      = 17
) (
  input  logic     clock,
  input  logic     reset,
  input  logic     load,
  input  pwm_cfg_t cfg,
  input  logic     period_end,
  output pwm_cfg_t live,
  output logic     pending,
  output logic     commit,
  output logic     late_commit
);

  cfg_state_t    state;
  pwm_cfg_t      shadow;
  logic [TW-1:0] wait_cnt;

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      shadow      <= '0;
      live        <= '0;
      wait_cnt    <= '0;
      commit      <= 1'b0;
      late_commit <= 1'b0;
    end else begin
      commit      <= 1'b0;
      late_commit <= 1'b0;
      case (state)
        IDLE: begin
          if (load) begin
            shadow   <= cfg;
            state    <= PENDING;
            wait_cnt <= '0;
          end
        end
        PENDING: begin
          if ((live.div == '0) || period_end) begin
            live   <= shadow;
            state  <= IDLE;
            commit <= 1'b1;
          end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
            live        <= shadow;
            state       <= IDLE;
            commit      <= 1'b1;
            late_commit <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pending = (state == PENDING);

endmodule

// File: rtl/pwm_cfg_sched.sv
// Schedules (high, top, div) updates into per-channel shadows, committing at period boundaries.
module pwm_cfg_sched
  import pwm_pkg::*;
#(
  parameter int unsigned NCHAN   = PWM_NCHAN,
  parameter int unsigned TIMEOUT = 65536,
  parameter int unsigned TW      = 17,
  localparam int unsigned CW     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [CW-1:0]       req_chan,
  input  logic [15:0]         req_high,
  input  logic [15:0]         req_top,
  input  logic [7:0]          req_div,
  output logic                req_err,
  input  logic [NCHAN-1:0]    period_end,
  output logic [16*NCHAN-1:0] act_high,
  output logic [16*NCHAN-1:0] act_top,
  output logic [8*NCHAN-1:0]  act_div,
  output logic [NCHAN-1:0]    pending,
  output logic [NCHAN-1:0]    commit,
  output logic [NCHAN-1:0]    late_commit
);

  pwm_cfg_t req_cfg;
  pwm_cfg_t live [NCHAN];
  logic     xfer;
  logic     ok;

  assign req_cfg   = '{high: req_high, top: req_top, div: req_div};
  assign req_ready = !reset && !pending[req_chan];
  assign xfer      = req_valid && req_ready;
  assign ok        = cfg_ok(req_cfg);

  // A rejected request still completes the handshake; only the error pulse records it.
  always_ff @(posedge clock) begin
    if (reset) req_err <= 1'b0;
    else       req_err <= xfer && !ok;
  end

  for (genvar c = 0; c < NCHAN; c++) begin : g_slot
    pwm_cfg_slot #(
      .TIMEOUT(TIMEOUT),
      .TW     (TW)
    ) u_slot (
      .clock      (clock),
      .reset      (reset),
      .load       (xfer && ok && (req_chan == CW'(c))),
      .cfg        (req_cfg),
      .period_end (period_end[c]),
      .live       (live[c]),
      .pending    (pending[c]),
      .commit     (commit[c]),
      .late_commit(late_commit[c])
    );
    assign act_high[16*c +: 16] = live[c].high;
    assign act_top[16*c +: 16]  = live[c].top;
    assign act_div[8*c +: 8]    = live[c].div;
  end

endmodule
